// File: rtl/dffram_rtl_2p_param.sv
// Two-port DFF RAM: port A read/write with byte lanes, port B read-only, zero-clear sweep after reset.
// Optional macro DFFRAM_OUT_REG_EN adds a second output register stage on both ports (latency 2).
module dffram_rtl_2p_param #(
  parameter int DATA_LENGTH    = 32,
  parameter int ADDRESS_LENGTH = 11,
  parameter int DEPTH          = 2048
) (
  input  logic                        CLK,
  input  logic                        RSTn,
  input  logic                        ENA,
  input  logic [DATA_LENGTH/8-1:0]    WEA,
  input  logic [ADDRESS_LENGTH-1:0]   AA,
  input  logic [DATA_LENGTH-1:0]      DiA,
  output logic [DATA_LENGTH-1:0]      DoA,
  output logic                        VALIDA,
  input  logic                        ENB,
  input  logic [ADDRESS_LENGTH-1:0]   AB,
  output logic [DATA_LENGTH-1:0]      DoB,
  output logic                        VALIDB,
  output logic                        BUSY
);

  localparam int NB   = DATA_LENGTH / 8;
  localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

  typedef enum logic {CLEAR, RUN} state_e;

  state_e                 state_q, state_d;
  logic [IDXW-1:0]        cnt_q, cnt_d;
  logic [DATA_LENGTH-1:0] mem_q [DEPTH];

  logic                   a_in_rng, b_in_rng;
  logic [IDXW-1:0]        a_idx, b_idx;
  logic [DATA_LENGTH-1:0] a_old, b_old;

  logic [DATA_LENGTH-1:0] doa_d, doa_q, dob_d, dob_q;
  logic                   valida_d, valida_q, validb_d, validb_q;

  // Range check is done before truncation so out-of-range addresses never alias.
  assign a_in_rng = ({1'b0, AA} < (ADDRESS_LENGTH + 1)'(DEPTH));
  assign b_in_rng = ({1'b0, AB} < (ADDRESS_LENGTH + 1)'(DEPTH));
  assign a_idx    = AA[IDXW-1:0];
  assign b_idx    = AB[IDXW-1:0];

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == CLEAR) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST_IDX) begin
        state_d = RUN;
        cnt_d   = '0;
      end
    end
  end

  assign BUSY = (state_q == CLEAR);

  // ---------------------------------------------------------------- array
  // NOTE: the array deliberately has no reset; the clear sweep initialises it after every reset.
  always_ff @(posedge CLK) begin
    if (state_q == CLEAR) begin
      mem_q[cnt_q] <= '0;
    end else if (ENA && a_in_rng) begin
      for (int i = 0; i < NB; i++) begin
        if (WEA[i]) mem_q[a_idx][8*i +: 8] <= DiA[8*i +: 8];
      end
    end
  end

  // ---------------------------------------------------------------- read stage 1
  // NOTE: combinational blocks use blocking assignments with every output defaulted first, so no latch is inferred.
  always_comb begin
    a_old    = a_in_rng ? mem_q[a_idx] : '0;
    b_old    = b_in_rng ? mem_q[b_idx] : '0;
    doa_d    = '0;
    dob_d    = '0;
    valida_d = 1'b0;
    validb_d = 1'b0;
    if (state_q == RUN) begin
      if (ENA) begin
        doa_d    = a_old;
        valida_d = 1'b1;
      end
      if (ENB) begin
        dob_d    = b_old;
        validb_d = 1'b1;
        // Write-first forwarding of the lanes port A writes this cycle.
        if (ENA && a_in_rng && (AA == AB)) begin
          for (int i = 0; i < NB; i++) begin
            if (WEA[i]) dob_d[8*i +: 8] = DiA[8*i +: 8];
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      doa_q    <= '0;
      dob_q    <= '0;
      valida_q <= 1'b0;
      validb_q <= 1'b0;
    end else begin
      doa_q    <= doa_d;
      dob_q    <= dob_d;
      valida_q <= valida_d;
      validb_q <= validb_d;
    end
  end

`ifdef DFFRAM_OUT_REG_EN
  logic [DATA_LENGTH-1:0] doa2_q, dob2_q;
  logic                   valida2_q, validb2_q;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      doa2_q    <= '0;
      dob2_q    <= '0;
      valida2_q <= 1'b0;
      validb2_q <= 1'b0;
    end else if (state_q == CLEAR) begin
      doa2_q    <= '0;
      dob2_q    <= '0;
      valida2_q <= 1'b0;
      validb2_q <= 1'b0;
    end else begin
      doa2_q    <= doa_q;
      dob2_q    <= dob_q;
      valida2_q <= valida_q;
      validb2_q <= validb_q;
    end
  end

  assign DoA    = doa2_q;
  assign DoB    = dob2_q;
  assign VALIDA = valida2_q;
  assign VALIDB = validb2_q;
`else
  assign DoA    = doa_q;
  assign DoB    = dob_q;
  assign VALIDA = valida_q;
  assign VALIDB = validb_q;
`endif

endmodule

// File: tb/tb_dffram_rtl_2p_param.sv
// Bench for dffram_rtl_2p_param (DEPTH=16): directed test-plan steps plus randomized traffic
// against an associative-array memory model with an expected-output latency pipeline.
module tb_dffram_rtl_2p_param;

  localparam int DL  = 32;
  localparam int AL  = 5;
  localparam int DEP = 16;
  localparam int NB  = DL / 8;
`ifdef DFFRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          CLK = 1'b0;
  logic          RSTn = 1'b0;
  logic          ENA = 1'b0, ENB = 1'b0;
  logic [NB-1:0] WEA = '0;
  logic [AL-1:0] AA = '0, AB = '0;
  logic [DL-1:0] DiA = '0;
  logic [DL-1:0] DoA, DoB;
  logic          VALIDA, VALIDB, BUSY;

  dffram_rtl_2p_param #(.DATA_LENGTH(DL), .ADDRESS_LENGTH(AL), .DEPTH(DEP)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .ENA(ENA), .WEA(WEA), .AA(AA), .DiA(DiA), .DoA(DoA), .VALIDA(VALIDA),
    .ENB(ENB), .AB(AB), .DoB(DoB), .VALIDB(VALIDB),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic          va;
    logic          vb;
    logic [DL-1:0] da;
    logic [DL-1:0] db;
  } exp_t;

  int            checks   = 0;
  int            failures = 0;
  logic [DL-1:0] model [int];   // absent key == zero (the sweep clears everything)
  int            busy_left;
  exp_t          pipe [LAT];

  task automatic check(input string tag, input logic [DL-1:0] obs, input logic [DL-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DL-1:0] rd(input int a);
    if (a >= DEP) return '0;
    return model.exists(a) ? model[a] : '0;
  endfunction

  task automatic do_reset();
    RSTn = 1'b0;
    #2;
    check("rst_busy",   DL'(BUSY),   DL'(1));
    check("rst_doa",    DoA,         '0);
    check("rst_dob",    DoB,         '0);
    check("rst_valida", DL'(VALIDA), '0);
    check("rst_validb", DL'(VALIDB), '0);
    @(negedge CLK);
    RSTn = 1'b1;
    model.delete();
    busy_left = DEP;
    for (int i = 0; i < LAT; i++) pipe[i] = '0;
  endtask

  // One clock: drive inputs, predict from the model, check outputs after the edge.
  task automatic step(input logic ena, input logic [NB-1:0] wea, input logic [AL-1:0] aa,
                      input logic [DL-1:0] dia, input logic enb, input logic [AL-1:0] ab);
    exp_t          e;
    logic [DL-1:0] w;
    int            ia, ib;
    e  = '0;
    ia = int'(aa);
    ib = int'(ab);
    ENA = ena; WEA = wea; AA = aa; DiA = dia; ENB = enb; AB = ab;
    if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (ena) begin
        e.va = 1'b1;
        e.da = rd(ia);
        if (ia < DEP) begin
          w = rd(ia);
          for (int i = 0; i < NB; i++) if (wea[i]) w[8*i +: 8] = dia[8*i +: 8];
          model[ia] = w;
        end
      end
      if (enb) begin
        e.vb = 1'b1;
        e.db = rd(ib);   // after port A's write: write-first as seen by B
      end
    end
    @(posedge CLK);
    #1;
    for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = e;
    check("doa",    DoA,         pipe[LAT-1].da);
    check("valida", DL'(VALIDA), DL'(pipe[LAT-1].va));
    check("dob",    DoB,         pipe[LAT-1].db);
    check("validb", DL'(VALIDB), DL'(pipe[LAT-1].vb));
    check("busy",   DL'(BUSY),   DL'(busy_left > 0));
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic settle();
    repeat (LAT - 1) idle();
  endtask

  task automatic count_busy(output int n);
    n = 0;
    for (int k = 0; k < 4 * DEP; k++) begin
      if (!BUSY) break;
      idle();
      n++;
    end
  endtask

  initial begin
    int n;
    logic          ena, enb;
    logic [NB-1:0] wea;
    logic [AL-1:0] aa, ab;

    // Reset and sweep: preload RAM[5], reset, sweep must wipe it.
    do_reset();
    count_busy(n);
    check("sweep_len_first", DL'(n), DL'(DEP));
    step(1'b1, 4'hF, AL'(5), 32'hDEADBEEF, 1'b0, '0);
    do_reset();
    count_busy(n);
    check("sweep_len", DL'(n), DL'(DEP));
    step(1'b1, 4'h0, AL'(5), '0, 1'b0, '0);
    settle();
    check("sweep_cleared_doa", DoA, '0);
    check("sweep_cleared_va",  DL'(VALIDA), DL'(1));

    // Byte lanes.
    step(1'b1, 4'hF,    AL'(3), 32'h11223344, 1'b0, '0);
    step(1'b1, 4'b0101, AL'(3), 32'hAABBCCDD, 1'b0, '0);
    step(1'b1, 4'h0,    AL'(3), '0,           1'b0, '0);
    settle();
    check("byte_lanes", DoA, 32'h11BB33DD);

    // Read-first on port A.
    step(1'b1, 4'hF, AL'(7), 32'h1, 1'b0, '0);
    step(1'b1, 4'hF, AL'(7), 32'h2, 1'b0, '0);
    settle();
    check("read_first_old", DoA, 32'h1);
    step(1'b1, 4'h0, AL'(7), '0, 1'b0, '0);
    settle();
    check("read_first_new", DoA, 32'h2);

    // Collision forwarding to port B.
    step(1'b1, 4'b0011, AL'(9), 32'hFFFFFFFF, 1'b1, AL'(9));
    settle();
    check("collide_dob", DoB, 32'h0000FFFF);
    check("collide_doa", DoA, 32'h0);

    // Out of range: no aliasing onto RAM[4].
    step(1'b1, 4'hF, AL'(4),  32'h77, 1'b0, '0);
    step(1'b1, 4'hF, AL'(20), 32'h5,  1'b1, AL'(20));
    settle();
    check("oor_doa",    DoA,         '0);
    check("oor_valida", DL'(VALIDA), DL'(1));
    check("oor_validb", DL'(VALIDB), DL'(1));
    step(1'b1, 4'h0, AL'(4), '0, 1'b1, AL'(20));
    settle();
    check("oor_no_alias", DoA, 32'h77);
    check("oor_read_b",   DoB, '0);

    // Accesses during sweep are ignored; reset at sweep cycle 8 restarts it.
    do_reset();
    repeat (8) step(1'b1, 4'hF, AL'(2), 32'hCAFEF00D, 1'b1, AL'(2));
    check("busy_doa",    DoA,         '0);
    check("busy_validb", DL'(VALIDB), '0);
    do_reset();
    count_busy(n);
    check("sweep_restart_len", DL'(n), DL'(DEP));
    step(1'b1, 4'h0, AL'(2), '0, 1'b1, AL'(2));
    settle();
    check("sweep_ignored_write", DoA, '0);

    // Randomized traffic with frequent collisions and out-of-range addresses.
    for (int t = 0; t < 400; t++) begin
      ena = ($urandom_range(0, 3) != 0);
      enb = ($urandom_range(0, 3) != 0);
      wea = NB'($urandom);
      aa  = AL'($urandom_range(0, DEP + 7));
      ab  = ($urandom_range(0, 2) == 0) ? aa : AL'($urandom_range(0, DEP + 7));
      step(ena, wea, aa, $urandom, enb, ab);
    end
    repeat (LAT) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dffram_rtl_2p_param.md
Name: dffram_rtl_2p_param

Overview:
- Parametrised successor to the team's single-port 2048x32 DFF RAM.
- Port A is read/write with byte-lane write enables. Port B is read-only.
- Same-address A-write/B-read collisions are forwarded write-first to port B.
- After reset, a built-in sweep clears the whole array to zero before the block accepts accesses. Used as shared data memory between the core and a debug/DMA reader.

Parameters:
- DATA_LENGTH, 32, word width in bits; must be a multiple of 8; NB = DATA_LENGTH/8 byte lanes (localparam).
- ADDRESS_LENGTH, 11, address width in bits.
- DEPTH, 2048, number of words; must satisfy DEPTH <= 2**ADDRESS_LENGTH.

Ports:
- CLK  in  1  clock, all state on rising edge.
- RSTn  in  1  asynchronous active-low reset.
- ENA  in  1  port A access enable.
- WEA  in  NB  port A byte write enables; bit i writes Di bits [8i+7:8i].
- AA  in  ADDRESS_LENGTH  port A word address.
- DiA  in  DATA_LENGTH  port A write data.
- DoA  out  DATA_LENGTH  port A read data (registered).
- VALIDA  out  1  DoA holds data from an accepted access.
- ENB  in  1  port B read enable.
- AB  in  ADDRESS_LENGTH  port B word address.
- DoB  out  DATA_LENGTH  port B read data (registered).
- VALIDB  out  1  DoB holds data from an accepted access.
- BUSY  out  1  clear sweep in progress; accesses ignored.

Behaviour:
- Reset (RSTn=0, asynchronous): DoA=0, DoB=0, VALIDA=0, VALIDB=0, BUSY=1, state=CLEAR, sweep counter=0. Array contents are not reset asynchronously.
- FSM states:
  - CLEAR: each CLK writes all-zero to RAM[cnt], then cnt<=cnt+1. When cnt==DEPTH-1 is written, next state is RUN and BUSY<=0. The sweep takes exactly DEPTH cycles after RSTn release.
  - RUN: normal operation; there is no exit except reset.
- In CLEAR: ENA/ENB/WEA ignored; DoA/DoB held 0; VALIDA/VALIDB held 0.
- Port A in RUN (latency 1):
  - ENA=1: DoA<=RAM[AA] (read-first: old contents even when writing). Each set WEA[i] updates byte lane i. VALIDA<=1.
  - ENA=0: DoA<=0, VALIDA<=0, no write.
- Port B in RUN (latency 1):
  - ENB=1: DoB<=RAM[AB], VALIDB<=1.
  - ENB=0: DoB<=0, VALIDB<=0.
- Collision: if ENA=1, ENB=1, AA==AB and WEA!=0 in the same cycle, DoB lane i = DiA lane i where WEA[i]=1, else the old RAM lane (write-first forwarding). DoA stays read-first.
- Out of range (address >= DEPTH): read returns 0 with VALID=1. Port A write is dropped, with no aliasing or wrap-around.
- Reset asserted mid-sweep or mid-operation: the sweep restarts from 0 after release. Contents written before reset are overwritten by the sweep.
- All lanes independent: a partial WEA leaves unselected bytes unchanged.

Optional Feature:
- Macro DFFRAM_OUT_REG_EN.
- Defined: adds a second output register stage on both ports. Read latency becomes 2 for DoA/DoB and VALIDA/VALIDB, which travel together through the pipeline. The extra stage resets to 0 and is held 0 during CLEAR. Collision forwarding is computed at stage 1 and carried unchanged.
- Undefined: latency 1 as above.

Test Plan:
- Reset/sweep, DEPTH=16: preload RAM[5]=32'hDEADBEEF via backdoor, pulse RSTn low -> BUSY=1 for exactly 16 cycles after release, then BUSY=0; read A=5 -> DoA=0, VALIDA=1 next cycle.
- Byte lanes: write AA=3 DiA=32'h11223344 WEA=4'hF, then DiA=32'hAABBCCDD WEA=4'b0101 -> read AA=3 gives DoA=32'h11BB33DD.
- Read-first on A: RAM[7]=32'h1, ENA=1 WEA=4'hF AA=7 DiA=32'h2 -> DoA=32'h1 that cycle; next read -> 32'h2.
- Collision forwarding: RAM[9]=32'h00000000, same cycle AA=AB=9 WEA=4'b0011 DiA=32'hFFFFFFFF, ENB=1 -> DoB=32'h0000FFFF, DoA=32'h0.
- Out of range, DEPTH=16: ENA=1 AA=20 WEA=4'hF DiA=32'h5 -> DoA=0, VALIDA=1; RAM[4] unchanged (no aliasing).
- Disabled/mid-sweep: ENA=ENB=1 during BUSY -> DoA=DoB=0, VALIDA=VALIDB=0; RSTn low at sweep cycle 8 -> sweep restarts and BUSY lasts another full 16 cycles.
